fifo_read_ctrl: RTL and testbench

- Read-domain controller for the asynchronous FIFO; runs in the read clock domain.
- Owns the binary and Gray read pointers and brings the write-domain Gray pointer across with a two-flop synchronizer.
- Produces a registered `empty` flag, occupancy and almost-empty status, the memory read strobe/address, and a data-valid strobe aligned to the memory's registered `r_data`.
- It is the consuming-end counterpart to the write-side logic that fills the shared FIFO memory.

---
 rtl/fifo_read_ctrl.sv | 82 ++++++++
 tb/tb_fifo_read_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl.sv
// Read-domain side of the async FIFO: read pointers, write-pointer
// synchronizer, and the registered empty/level/almost-empty status.
module fifo_read_ctrl #(
   parameter int Address = 2
) (
   input  logic               r_clk,
   input  logic               r_rst,
   input  logic [Address:0]   w_gptr,
   input  logic               r_req,
   output logic               r_en,
   output logic [Address:0]   r_addr,
   output logic [Address:0]   r_gptr,
   output logic               empty,
   output logic               almost_empty,
   output logic [Address:0]   r_level,
   output logic               r_valid,
   output logic               underflow
);

   logic [Address:0] r_bin;
   logic [Address:0] r_gray;
   logic [Address:0] r_wq1;
   logic [Address:0] r_wq2;
   logic [Address:0] r_lvl;
   logic             r_empty;
   logic             r_aempty;
   logic             r_vld;
   logic             r_unf;

   logic [Address:0] w_bin_next;
   logic [Address:0] w_gray_next;
   logic [Address:0] w_wbin;
   logic [Address:0] w_lvl_next;

   assign r_en        = r_req & ~r_empty;
   assign w_bin_next  = r_bin + (Address+1)'(r_en);
   assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

   // Gray-to-binary of the synchronized write pointer: bit i is the
   // XOR of all Gray bits at and above i.
   always_comb begin
      w_wbin = '0;
      for (int i = 0; i <= Address; i++) begin
         w_wbin[i] = ^(r_wq2 >> i);
      end
   end

   assign w_lvl_next = w_wbin - w_bin_next;

   always_ff @(posedge r_clk) begin
      if (r_rst) begin
         r_bin    <= '0;
         r_gray   <= '0;
         r_wq1    <= '0;
         r_wq2    <= '0;
         r_lvl    <= '0;
         r_empty  <= 1'b1;
         r_aempty <= 1'b1;
         r_vld    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         r_wq1    <= w_gptr;
         r_wq2    <= r_wq1;
         r_bin    <= w_bin_next;
         r_gray   <= w_gray_next;
         r_empty  <= (w_gray_next == r_wq2);
         r_lvl    <= w_lvl_next;
         r_aempty <= (w_lvl_next <= (Address+1)'(1));
         r_vld    <= r_en;
         r_unf    <= r_req & r_empty;
      end
   end

   assign r_addr       = r_bin;
   assign r_gptr       = r_gray;
   assign empty        = r_empty;
   assign almost_empty = r_aempty;
   assign r_level      = r_lvl;
   assign r_valid      = r_vld;
   assign underflow    = r_unf;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: write-side and memory model feed a data
// scoreboard; directed phases check flags, pointers and timing.
module tb_fifo_read_ctrl;

   logic       r_clk;
   logic       r_rst;
   logic [2:0] w_gptr;
   logic       r_req;
   logic       r_en;
   logic [2:0] r_addr;
   logic [2:0] r_gptr;
   logic       empty;
   logic       almost_empty;
   logic [2:0] r_level;
   logic       r_valid;
   logic       underflow;

   int errors = 0;
   int checks = 0;

   logic [7:0] mem [4];
   logic [7:0] r_data;
   logic [7:0] sb_q [$];
   logic [2:0] gseq [8];
   int         wbin;
   int         wcnt;
   int         exp_rbin;
   int         n;
   logic       en_d;

   fifo_read_ctrl #(.Address(2)) dut (
      .r_clk       (r_clk),
      .r_rst       (r_rst),
      .w_gptr      (w_gptr),
      .r_req       (r_req),
      .r_en        (r_en),
      .r_addr      (r_addr),
      .r_gptr      (r_gptr),
      .empty       (empty),
      .almost_empty(almost_empty),
      .r_level     (r_level),
      .r_valid     (r_valid),
      .underflow   (underflow)
   );

   initial r_clk = 1'b0;
   always #5 r_clk = ~r_clk;

   // Registered memory read port, as the shared FIFO RAM behaves
   always @(posedge r_clk) begin
      if (r_en) r_data <= mem[r_addr[1:0]];
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: every r_valid must present the oldest written word
   always @(negedge r_clk) begin
      if (r_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra: got data %0h expected none", r_data);
         end else begin
            chk("sb_data", 32'(r_data), 32'(sb_q.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge r_clk);
      #1;
   endtask

   task automatic wr();
      logic [7:0] d;
      d = 8'hA0 + 8'(wcnt);
      wcnt++;
      mem[wbin & 3] = d;
      sb_q.push_back(d);
      wbin++;
      w_gptr = gseq[wbin & 7];
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      gseq[0] = 3'b000; gseq[1] = 3'b001;
      gseq[2] = 3'b011; gseq[3] = 3'b010;
      gseq[4] = 3'b110; gseq[5] = 3'b111;
      gseq[6] = 3'b101; gseq[7] = 3'b100;
      wbin = 0;
      wcnt = 0;
      w_gptr = 3'b000;

      // Reset with two entries already written (w_gptr = 011)
      r_rst = 1'b1;
      r_req = 1'b1;
      wr();
      wr();
      tick();
      tick();
      chk("rst_empty", 32'(empty), 1);
      chk("rst_aempty", 32'(almost_empty), 1);
      chk("rst_level", 32'(r_level), 0);
      chk("rst_addr", 32'(r_addr), 0);
      chk("rst_gptr", 32'(r_gptr), 0);
      chk("rst_valid", 32'(r_valid), 0);
      chk("rst_en", 32'(r_en), 0);
      r_rst = 1'b0;
      r_req = 1'b0;
      tick();
      tick();
      chk("sync_e2_empty", 32'(empty), 1);
      tick();
      chk("sync_e3_empty", 32'(empty), 0);
      chk("sync_e3_level", 32'(r_level), 2);
      chk("sync_e3_aempty", 32'(almost_empty), 0);

      // Drain both entries
      r_req = 1'b1;
      #1;
      chk("drain_en", 32'(r_en), 1);
      tick();
      chk("drain1_level", 32'(r_level), 1);
      chk("drain1_aempty", 32'(almost_empty), 1);
      chk("drain1_empty", 32'(empty), 0);
      chk("drain1_addr", 32'(r_addr), 1);
      tick();
      chk("drain2_level", 32'(r_level), 0);
      chk("drain2_empty", 32'(empty), 1);
      chk("drain2_addr", 32'(r_addr), 2);
      chk("drain2_gptr", 32'(r_gptr), 3);
      chk("drain2_en", 32'(r_en), 0);
      r_req = 1'b0;

      // Single-write visibility latency
      wr();
      tick();
      chk("lat_e1_empty", 32'(empty), 1);
      tick();
      chk("lat_e2_empty", 32'(empty), 1);
      tick();
      chk("lat_e3_empty", 32'(empty), 0);
      chk("lat_e3_level", 32'(r_level), 1);
      chk("lat_e3_aempty", 32'(almost_empty), 1);
      r_req = 1'b1;
      #1;
      chk("lat_rd_en", 32'(r_en), 1);
      tick();
      chk("lat_rd_empty", 32'(empty), 1);
      chk("lat_rd_level", 32'(r_level), 0);
      chk("lat_rd_addr", 32'(r_addr), 3);
      chk("lat_rd_valid", 32'(r_valid), 1);

      // Underflow: request held while empty
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("unf_en", 32'(r_en), 0);
         tick();
         chk("unf_pulse", 32'(underflow), 1);
         chk("unf_addr", 32'(r_addr), 3);
         chk("unf_gptr", 32'(r_gptr), 2);
      end
      r_req = 1'b0;
      tick();
      chk("unf_clear", 32'(underflow), 0);

      // Ten single-entry write/read pairs across the wrap point
      exp_rbin = 3;
      for (int i = 0; i < 10; i++) begin
         wr();
         tick();
         tick();
         tick();
         chk("wrap_level_pre", 32'(r_level), 1);
         r_req = 1'b1;
         #1;
         chk("wrap_en", 32'(r_en), 1);
         tick();
         r_req = 1'b0;
         exp_rbin++;
         chk("wrap_addr", 32'(r_addr), 32'(exp_rbin & 7));
         chk("wrap_gptr", 32'(r_gptr), 32'(gseq[exp_rbin & 7]));
         chk("wrap_level_post", 32'(r_level), 0);
      end

      // Reset, fill to full (w_gptr = 110), drain with r_req held
      r_rst = 1'b1;
      wbin = 0;
      w_gptr = 3'b000;
      tick();
      tick();
      chk("rst2_addr", 32'(r_addr), 0);
      r_rst = 1'b0;
      for (int i = 0; i < 4; i++) wr();
      tick();
      tick();
      tick();
      chk("full_level", 32'(r_level), 4);
      chk("full_aempty", 32'(almost_empty), 0);
      chk("full_empty", 32'(empty), 0);
      r_req = 1'b1;
      n = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         en_d = r_en;
         if (en_d) chk("full_addr", 32'(r_addr), 32'(n));
         tick();
         if (en_d) n++;
         chk("full_valid", 32'(r_valid), 32'(en_d));
         if (en_d) chk("full_level_dn", 32'(r_level), 32'(4 - n));
      end
      chk("full_reads", 32'(n), 4);
      chk("full_end_empty", 32'(empty), 1);
      chk("full_end_gptr", 32'(r_gptr), 6);
      r_req = 1'b0;
      tick();

      // Reset arriving with an accepted read in flight
      for (int i = 0; i < 3; i++) wr();
      tick();
      tick();
      tick();
      chk("mid_level", 32'(r_level), 3);
      r_req = 1'b1;
      #1;
      chk("mid_en", 32'(r_en), 1);
      r_rst = 1'b1;
      sb_q.delete();
      tick();
      chk("mid_valid", 32'(r_valid), 0);
      chk("mid_addr", 32'(r_addr), 0);
      chk("mid_empty", 32'(empty), 1);
      chk("mid_level0", 32'(r_level), 0);
      r_rst = 1'b0;
      r_req = 1'b0;
      wbin = 0;
      w_gptr = 3'b000;
      tick();
      tick();
      chk("sb_leftover", 32'(sb_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
